// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the MIPS execute stage.
//   - default datapath widths
//   - ALU opcode encodings
//   - forwarding select codes
//   - multiplier FSM state encoding
package ex_pkg;

  localparam int NB_DATA_DEF   = 32;
  localparam int NB_REG_DEF    = 5;
  localparam int NB_MUX_DEF    = 2;
  localparam int NB_ALU_OP_DEF = 4;
  localparam int NB_SHAMT      = 5;
  localparam int NB_MUL_CNT    = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_MULT = 4'b1100;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  typedef enum logic {
    MUL_IDLE = 1'b0,
    MUL_RUN  = 1'b1
  } mul_state_t;

endpackage

// File: rtl/ex_alu.sv
// ex_alu: combinational ALU for all single-cycle operations.
// Ports:
//   a, b    operands (b is already muxed with the immediate)
//   op      ALU opcode (ex_pkg ALU_*); MULT and undefined codes give 0
//   shamt   shift amount for SLL/SRL/SRA (shifts apply to b)
//   result  operation result
module ex_alu
  import ex_pkg::*;
#(
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NB_ALU_OP = NB_ALU_OP_DEF
) (
  input  logic [NB_DATA-1:0]   a,
  input  logic [NB_DATA-1:0]   b,
  input  logic [NB_ALU_OP-1:0] op,
  input  logic [NB_SHAMT-1:0]  shamt,
  output logic [NB_DATA-1:0]   result
);

  logic signed [NB_DATA-1:0] a_s;
  logic signed [NB_DATA-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(NB_DATA-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: result = {{(NB_DATA-1){1'b0}}, (a < b)};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = b_s >>> shamt;
      ALU_LUI:  result = {b[15:0], {(NB_DATA-16){1'b0}}};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage MIPS pipeline.
// Applies the forwarding selects to the ID/EX operands, runs the ALU and
// registers result plus MEM control into the EX/MEM register (_p1 signals).
// Optional feature macro: EX_MULT_EN adds an iterative 32-step shift-add
// multiplier for op MULT; while it runs o_busy is high and EX/MEM loads
// bubbles. Without the macro MULT yields 0 in one cycle and o_busy is 0.
// Ports:
//   i_clock, i_reset          clock, synchronous active-high reset
//   i_valid, i_stall, i_flush ID/EX valid, hold EX/MEM, load bubble
//   i_forwarding_a/_b         00 regfile, 01 EX/MEM, 10 MEM/WB, 11 regfile
//   i_data_a/_b, i_MEM_result, i_WB_data, i_imm   operand sources
//   i_alu_src, i_alu_op, i_shamt                  ALU controls
//   i_rd, i_write_reg, i_mem_read, i_mem_write    passed to MEM
//   o_EX_MEM_rd, o_MEM_write_reg, o_mem_read, o_mem_write, o_valid,
//   o_alu_result, o_store_data, o_zero            EX/MEM register
//   o_busy                    combinational multiplier busy
module ex_stage
  import ex_pkg::*;
#(
  parameter int NB_DATA   = NB_DATA_DEF,
  parameter int NB_REG    = NB_REG_DEF,
  parameter int NB_MUX    = NB_MUX_DEF,
  parameter int NB_ALU_OP = NB_ALU_OP_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic                 i_flush,
  input  logic [NB_MUX-1:0]    i_forwarding_a,
  input  logic [NB_MUX-1:0]    i_forwarding_b,
  input  logic [NB_DATA-1:0]   i_data_a,
  input  logic [NB_DATA-1:0]   i_data_b,
  input  logic [NB_DATA-1:0]   i_MEM_result,
  input  logic [NB_DATA-1:0]   i_WB_data,
  input  logic [NB_DATA-1:0]   i_imm,
  input  logic                 i_alu_src,
  input  logic [NB_ALU_OP-1:0] i_alu_op,
  input  logic [4:0]           i_shamt,
  input  logic [NB_REG-1:0]    i_rd,
  input  logic                 i_write_reg,
  input  logic                 i_mem_read,
  input  logic                 i_mem_write,
  output logic [NB_REG-1:0]    o_EX_MEM_rd,
  output logic                 o_MEM_write_reg,
  output logic                 o_mem_read,
  output logic                 o_mem_write,
  output logic                 o_valid,
  output logic [NB_DATA-1:0]   o_alu_result,
  output logic [NB_DATA-1:0]   o_store_data,
  output logic                 o_zero,
  output logic                 o_busy
);

  // ---- stage p0: forwarding muxes and ALU ----
  logic [NB_DATA-1:0] fwd_a_p0, fwd_b_p0, alu_b_p0, alu_res_p0;

  always_comb begin
    case (i_forwarding_a)
      FWD_MEM: fwd_a_p0 = i_MEM_result;
      FWD_WB:  fwd_a_p0 = i_WB_data;
      default: fwd_a_p0 = i_data_a;
    endcase
    case (i_forwarding_b)
      FWD_MEM: fwd_b_p0 = i_MEM_result;
      FWD_WB:  fwd_b_p0 = i_WB_data;
      default: fwd_b_p0 = i_data_b;
    endcase
  end

  assign alu_b_p0 = i_alu_src ? i_imm : fwd_b_p0;

  ex_alu #(.NB_DATA(NB_DATA), .NB_ALU_OP(NB_ALU_OP)) u_alu (
    .a      (fwd_a_p0),
    .b      (alu_b_p0),
    .op     (i_alu_op),
    .shamt  (i_shamt),
    .result (alu_res_p0)
  );

`ifdef EX_MULT_EN
  mul_state_t            state_q, state_d;
  logic [NB_MUL_CNT-1:0] cnt_q;
  logic [NB_DATA-1:0]    mcand_q, mplier_q, acc_q, acc_step, mstore_q;
  logic [NB_REG-1:0]     mrd_q;
  logic                  mwr_q, mmr_q, mmw_q;
  logic                  mul_req, mul_start, mul_done;

  assign mul_req  = i_valid && (i_alu_op == ALU_MULT);
  // Multiplicand shifts left, multiplier shifts right: one partial product per step.
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign o_busy   = ((state_q == MUL_IDLE) && mul_req) || (state_q == MUL_RUN);

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    case (state_q)
      MUL_IDLE: begin
        // A flushed MULT is killed rather than started.
        if (mul_req && !i_stall && !i_flush) begin
          state_d   = MUL_RUN;
          mul_start = 1'b1;
        end
      end
      MUL_RUN: begin
        if (!i_stall) begin
          if (i_flush) begin
            state_d = MUL_IDLE;
          end else if (cnt_q == {NB_MUL_CNT{1'b1}}) begin
            state_d  = MUL_IDLE;
            mul_done = 1'b1;
          end
        end
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (mul_start)
        cnt_q <= '0;
      else if ((state_q == MUL_RUN) && !i_stall)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (mul_start) begin
      mcand_q  <= fwd_a_p0;
      mplier_q <= fwd_b_p0;
      acc_q    <= '0;
      mstore_q <= fwd_b_p0;
      mrd_q    <= i_rd;
      mwr_q    <= i_write_reg;
      mmr_q    <= i_mem_read;
      mmw_q    <= i_mem_write;
    end else if ((state_q == MUL_RUN) && !i_stall) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      acc_q    <= acc_step;
    end
  end
`else
  assign o_busy = 1'b0;
`endif

  // ---- stage p1: EX/MEM register ----
  logic [NB_REG-1:0]  rd_d;
  logic               wr_d, mr_d, mw_d, vld_d, zero_d;
  logic [NB_DATA-1:0] res_d, store_d;

  always_comb begin
    rd_d    = '0;
    wr_d    = 1'b0;
    mr_d    = 1'b0;
    mw_d    = 1'b0;
    vld_d   = 1'b0;
    zero_d  = 1'b0;
    res_d   = '0;
    store_d = '0;
    if (i_flush) begin
      vld_d = 1'b0;
`ifdef EX_MULT_EN
    end else if (mul_done) begin
      vld_d   = 1'b1;
      rd_d    = mrd_q;
      wr_d    = mwr_q;
      mr_d    = mmr_q;
      mw_d    = mmw_q;
      res_d   = acc_step;
      store_d = mstore_q;
      zero_d  = (acc_step == '0);
    end else if (o_busy) begin
      vld_d = 1'b0;
`endif
    end else if (i_valid) begin
      vld_d   = 1'b1;
      rd_d    = i_rd;
      wr_d    = i_write_reg;
      mr_d    = i_mem_read;
      mw_d    = i_mem_write;
      res_d   = alu_res_p0;
      store_d = fwd_b_p0;
      zero_d  = (alu_res_p0 == '0);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_EX_MEM_rd     <= '0;
      o_MEM_write_reg <= 1'b0;
      o_mem_read      <= 1'b0;
      o_mem_write     <= 1'b0;
      o_valid         <= 1'b0;
      o_alu_result    <= '0;
      o_store_data    <= '0;
      o_zero          <= 1'b0;
    end else if (!i_stall) begin
      o_EX_MEM_rd     <= rd_d;
      o_MEM_write_reg <= wr_d;
      o_mem_read      <= mr_d;
      o_mem_write     <= mw_d;
      o_valid         <= vld_d;
      o_alu_result    <= res_d;
      o_store_data    <= store_d;
      o_zero          <= zero_d;
    end
  end

endmodule
